// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 device-to-host frame receiver with ps2c glitch filter.
// Optional odd-parity check enabled by defining PS2_RX_PARITY_CHK_EN.
module ps2_rx_frame #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       rx_en,
    output logic       rx_done_tick,
    output logic [7:0] dout,
    output logic       parity_err,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, DPS, LOAD} state_t;

    state_t                state;
    logic [FILTER_LEN-1:0] filter_reg;
    logic                  f_ps2c;
    logic                  f_ps2c_next;
    logic                  fall_edge;
    logic [10:0]           b_reg;
    logic [10:0]           b_next;
    logic [3:0]            n;
    logic [TW-1:0]         tmo;
    logic                  parity_bad;
    logic                  unused_start;

    always_comb begin
        f_ps2c_next = f_ps2c;
        if (&filter_reg)
            f_ps2c_next = 1'b1;
        else if (~|filter_reg)
            f_ps2c_next = 1'b0;
    end

    assign fall_edge    = f_ps2c & ~f_ps2c_next;
    assign b_next       = {ps2d, b_reg[10:1]};
    assign unused_start = b_reg[0];

`ifdef PS2_RX_PARITY_CHK_EN
    assign parity_bad = ~(^b_next[9:1]);
`else
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filter_reg <= '1;
            f_ps2c     <= 1'b1;
        end else begin
            filter_reg <= {ps2c, filter_reg[FILTER_LEN-1:1]};
            f_ps2c     <= f_ps2c_next;
        end
    end

    // Strobes are decided on the 11th edge from b_next so they are registered and
    // appear exactly while the FSM sits in LOAD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            b_reg        <= '0;
            n            <= '0;
            tmo          <= '0;
            rx_done_tick <= 1'b0;
            dout         <= '0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            dout         <= '0;
            case (state)
                IDLE: begin
                    if (fall_edge && rx_en && !ps2d) begin
                        b_reg <= b_next;
                        n     <= 4'd9;
                        tmo   <= '0;
                        state <= DPS;
                    end
                end
                DPS: begin
                    if (fall_edge) begin
                        b_reg <= b_next;
                        tmo   <= '0;
                        if (n == 4'd0) begin
                            state <= LOAD;
                            if (!b_next[10])
                                frame_err <= 1'b1;
                            else if (parity_bad)
                                parity_err <= 1'b1;
                            else begin
                                rx_done_tick <= 1'b1;
                                dout         <= b_next[8:1];
                            end
                        end else begin
                            n <= n - 4'd1;
                        end
                    end else if (tmo == TW'(TIMEOUT_CYC - 1)) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                LOAD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - table-driven bench for ps2_rx_frame (FILTER_LEN=8, TIMEOUT_CYC=2000).
module tb_ps2_rx_frame;
    localparam int FL  = 8;
    localparam int TMO = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2c;
    logic       ps2d;
    logic       rx_en;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       parity_err;
    logic       frame_err;

    ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d), .rx_en(rx_en),
        .rx_done_tick(rx_done_tick), .dout(dout),
        .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_tick;
        logic [7:0] exp_dout;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int         n_tick = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         n_excl = 0;
    logic [7:0] last_dout = 8'h00;

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_done_tick) begin
                n_tick    = n_tick + 1;
                last_dout = dout;
            end
            if (frame_err)  n_ferr = n_ferr + 1;
            if (parity_err) n_perr = n_perr + 1;
            if (int'(rx_done_tick) + int'(frame_err) + int'(parity_err) > 1) n_excl = n_excl + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits, input int drop_at);
        for (int i = 0; i < nbits; i++) begin
            if (i == drop_at) rx_en = 1'b0;
            ps2d = bits[i];
            repeat (25) @(negedge clk);
            ps2c = 1'b0;
            repeat (50) @(negedge clk);
            ps2c = 1'b1;
            repeat (25) @(negedge clk);
        end
    endtask

    task automatic run_frame(input string name, input logic [7:0] data, input logic par,
                             input logic stop, input int exp_tick, input logic [7:0] exp_dout,
                             input int exp_ferr, input int exp_perr, input int drop_at);
        int t0, f0, p0;
        t0 = n_tick; f0 = n_ferr; p0 = n_perr;
        send_bits({stop, par, data, 1'b0}, 11, drop_at);
        repeat (20) @(negedge clk);
        check({name, "_tick"}, n_tick - t0, exp_tick);
        check({name, "_ferr"}, n_ferr - f0, exp_ferr);
        check({name, "_perr"}, n_perr - p0, exp_perr);
        if (exp_tick != 0) check({name, "_dout"}, int'(last_dout), int'(exp_dout));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   t0, f0, p0, lat, first, pulses;
        logic [10:0] fb;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h08, 1'b0, 1'b1, 1'b1, 8'h08, 1'b0, 1'b0};
        vecs[2] = '{8'hFA, 1'b1, 1'b1, 1'b1, 8'hFA, 1'b0, 1'b0};
`ifdef PS2_RX_PARITY_CHK_EN
        vecs[3] = '{8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
`else
        vecs[3] = '{8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
`endif
        vecs[4] = '{8'h3C, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[5] = '{8'h08, 1'b0, 1'b1, 1'b1, 8'h08, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

        reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; rx_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tick", int'(rx_done_tick), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_perr", int'(parity_err), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].par, vecs[i].stop,
                      int'(vecs[i].exp_tick), vecs[i].exp_dout,
                      int'(vecs[i].exp_ferr), int'(vecs[i].exp_perr), -1);

        // Latency: tick must follow the filtered 11th edge by one register stage.
        fb = {1'b1, 1'b1, 8'hC3, 1'b0};
        send_bits(fb, 10, -1);
        ps2d = 1'b1;
        repeat (25) @(negedge clk);
        ps2c = 1'b0;
        lat = -1;
        for (int k = 1; k <= 75; k++) begin
            @(negedge clk);
            if (k == 50) ps2c = 1'b1;
            if (rx_done_tick && lat < 0) begin
                lat = k;
                check("lat_dout", int'(dout), 8'hC3);
            end
        end
        check("lat_cycles", lat, FL + 1);
        repeat (20) @(negedge clk);

        // Inter-edge timeout after start + 4 data bits.
        t0 = n_tick;
        fb = {1'b1, 1'b1, 8'h0F, 1'b0};
        send_bits(fb, 4, -1);
        ps2d = fb[4];
        repeat (25) @(negedge clk);
        ps2c = 1'b0;
        first = -1; pulses = 0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (k == 50) ps2c = 1'b1;
            if (frame_err) begin
                pulses = pulses + 1;
                if (first < 0) first = k;
            end
        end
        check("tmo_first", first, FL + TMO + 1);
        check("tmo_pulses", pulses, 1);
        check("tmo_tick", n_tick - t0, 0);
        run_frame("after_tmo", 8'h55, 1'b1, 1'b1, 1, 8'h55, 0, 0, -1);

        // Short low glitch in IDLE must not start a frame.
        t0 = n_tick; f0 = n_ferr; p0 = n_perr;
        ps2d = 1'b0;
        repeat (10) @(negedge clk);
        ps2c = 1'b0;
        repeat (3) @(negedge clk);
        ps2c = 1'b1;
        repeat (100) @(negedge clk);
        ps2d = 1'b1;
        check("glitch_strobes", (n_tick - t0) + (n_ferr - f0) + (n_perr - p0), 0);
        run_frame("after_glitch", 8'h3C, 1'b1, 1'b1, 1, 8'h3C, 0, 0, -1);

        // rx_en low blocks a new frame; dropping it mid-frame does not abort.
        rx_en = 1'b0;
        run_frame("rxen_off", 8'hA5, 1'b1, 1'b1, 0, 8'h00, 0, 0, -1);
        rx_en = 1'b1;
        run_frame("rxen_drop", 8'h81, 1'b1, 1'b1, 1, 8'h81, 0, 0, 4);
        rx_en = 1'b1;

        // Reset mid-frame discards the partial frame.
        send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 7, -1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_tick", int'(rx_done_tick), 0);
        check("midrst_dout", int'(dout), 0);
        check("midrst_err", int'(frame_err) + int'(parity_err), 0);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        run_frame("after_rst", 8'h5A, 1'b1, 1'b1, 1, 8'h5A, 0, 0, -1);

        check("exclusive", n_excl, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
